// File: rtl/max_pool_multi.sv
// 2x2/stride-2 max pooling over K half-precision feature maps, one output element per clock.
// Inputs must stay stable from start until done; results are written in place into outputPool.
module max_pool_multi #(
  parameter int DATA_WIDTH = 16,
  parameter int H          = 28,
  parameter int W          = 28,
  parameter int K          = 6
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   start,
  input  logic [K*H*W*DATA_WIDTH-1:0]            inputConv,
  output logic [K*(H/2)*(W/2)*DATA_WIDTH-1:0]    outputPool,
  output logic                                   busy,
  output logic                                   done
);

  localparam int OH    = H / 2;
  localparam int OW    = W / 2;
  localparam int N_IN  = K * H * W;
  localparam int N_OUT = K * OH * OW;
  localparam int CH_W  = (K  > 1) ? $clog2(K)  : 1;
  localparam int OI_W  = (OH > 1) ? $clog2(OH) : 1;
  localparam int OJ_W  = (OW > 1) ? $clog2(OW) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CH_W-1:0]       r_ch;
  logic [OI_W-1:0]       r_oi;
  logic [OJ_W-1:0]       r_oj;
  logic                  w_last;
  logic [31:0]           w_base;
  logic [31:0]           w_out_idx;
  logic [DATA_WIDTH-1:0] w_e0;
  logic [DATA_WIDTH-1:0] w_e1;
  logic [DATA_WIDTH-1:0] w_e2;
  logic [DATA_WIDTH-1:0] w_e3;
  logic [DATA_WIDTH-1:0] w_max;

  // Strict "a > b" on raw half-precision bits; +0 and -0 compare equal, NaN/Inf are not special.
  function automatic logic hp_gt(input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] b);
    logic [DATA_WIDTH-2:0] ma;
    logic [DATA_WIDTH-2:0] mb;
    ma = a[DATA_WIDTH-2:0];
    mb = b[DATA_WIDTH-2:0];
    if (ma == '0 && mb == '0)
      return 1'b0;
    if (a[DATA_WIDTH-1] != b[DATA_WIDTH-1])
      return b[DATA_WIDTH-1];
    if (a[DATA_WIDTH-1])
      return ma < mb;
    return ma > mb;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] in_elem(input logic [31:0] idx);
    return inputConv[(N_IN - 1 - idx) * DATA_WIDTH +: DATA_WIDTH];
  endfunction

  assign w_last = (r_ch == CH_W'(K - 1)) && (r_oi == OI_W'(OH - 1)) && (r_oj == OJ_W'(OW - 1));

  assign w_base    = 32'(r_ch) * H * W + 2 * 32'(r_oi) * W + 2 * 32'(r_oj);
  assign w_out_idx = 32'(r_ch) * OH * OW + 32'(r_oi) * OW + 32'(r_oj);

  assign w_e0 = in_elem(w_base);
  assign w_e1 = in_elem(w_base + 1);
  assign w_e2 = in_elem(w_base + W);
  assign w_e3 = in_elem(w_base + W + 1);

  // Replace the running maximum only on a strict win so ties keep the earliest element.
  always_comb begin
    w_max = w_e0;
    if (hp_gt(w_e1, w_max)) w_max = w_e1;
    if (hp_gt(w_e2, w_max)) w_max = w_e2;
    if (hp_gt(w_e3, w_max)) w_max = w_e3;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start)  w_state_nxt = S_RUN;
      S_RUN:   if (w_last) w_state_nxt = S_DONE;
      S_DONE:  if (!start) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ch <= '0;
      r_oi <= '0;
      r_oj <= '0;
    end else if (r_state == S_IDLE && start) begin
      r_ch <= '0;
      r_oi <= '0;
      r_oj <= '0;
    end else if (r_state == S_RUN) begin
      if (r_oj == OJ_W'(OW - 1)) begin
        r_oj <= '0;
        if (r_oi == OI_W'(OH - 1)) begin
          r_oi <= '0;
          r_ch <= (r_ch == CH_W'(K - 1)) ? '0 : r_ch + 1'b1;
        end else begin
          r_oi <= r_oi + 1'b1;
        end
      end else begin
        r_oj <= r_oj + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      outputPool <= '0;
    else if (r_state == S_RUN)
      outputPool[(N_OUT - 1 - w_out_idx) * DATA_WIDTH +: DATA_WIDTH] <= w_max;
  end

  assign busy = (r_state == S_RUN);
  assign done = (r_state == S_DONE);

endmodule

// File: tb/tb_max_pool_multi.sv
// Randomised scoreboard bench for max_pool_multi on a 2 x 4x4 configuration.
module tb_max_pool_multi;

  localparam int DW = 16;
  localparam int H  = 4;
  localparam int W  = 4;
  localparam int K  = 2;
  localparam int NI = K * H * W;
  localparam int NO = K * (H / 2) * (W / 2);

  typedef logic [NO*DW-1:0] exp_t;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic [NI*DW-1:0] inputConv = '0;
  logic [NO*DW-1:0] outputPool;
  logic             busy;
  logic             done;

  logic [DW-1:0] in_mem [NI];
  exp_t          exp_q [$];
  exp_t          mon_e;
  int            n_checks = 0;
  int            n_err = 0;
  int            busy_cnt = 0;
  logic          prev_done = 1'b0;

  localparam logic [15:0] ONE_TO_16 [16] = '{
    16'h3C00, 16'h4000, 16'h4200, 16'h4400, 16'h4500, 16'h4600, 16'h4700, 16'h4800,
    16'h4880, 16'h4900, 16'h4980, 16'h4A00, 16'h4A80, 16'h4B00, 16'h4B80, 16'h4C00};

  max_pool_multi #(.DATA_WIDTH(DW), .H(H), .W(W), .K(K)) dut (
    .clk(clk), .reset(reset), .start(start), .inputConv(inputConv),
    .outputPool(outputPool), .busy(busy), .done(done));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Signed ordering key: magnitude with the sign applied, so +0 and -0 both map to 0.
  function automatic int key(input logic [15:0] v);
    int m;
    m = int'(v[14:0]);
    return v[15] ? -m : m;
  endfunction

  function automatic exp_t model();
    exp_t e;
    int   base;
    int   o;
    int   w[4];
    logic [15:0] best;
    e = '0;
    for (int k = 0; k < K; k++)
      for (int i = 0; i < H / 2; i++)
        for (int j = 0; j < W / 2; j++) begin
          base = k * H * W + 2 * i * W + 2 * j;
          w[0] = base; w[1] = base + 1; w[2] = base + W; w[3] = base + W + 1;
          best = in_mem[w[0]];
          for (int q = 1; q < 4; q++)
            if (key(in_mem[w[q]]) > key(best)) best = in_mem[w[q]];
          o = k * (H / 2) * (W / 2) + i * (W / 2) + j;
          e[(NO - 1 - o) * DW +: DW] = best;
        end
    return e;
  endfunction

  function automatic logic [15:0] pool_el(input int o);
    return outputPool[(NO - 1 - o) * DW +: DW];
  endfunction

  task automatic load();
    for (int n = 0; n < NI; n++) inputConv[(NI - 1 - n) * DW +: DW] = in_mem[n];
  endtask

  task automatic fill_random();
    int r;
    for (int n = 0; n < NI; n++) begin
      r = int'($urandom_range(0, 9));
      case (r)
        0: in_mem[n] = 16'h0000;
        1: in_mem[n] = 16'h8000;
        2: in_mem[n] = 16'h7C00;
        3: in_mem[n] = 16'hFE00;
        4: in_mem[n] = (n > 0) ? in_mem[n-1] : 16'hBC00;
        default: in_mem[n] = 16'($urandom);
      endcase
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 100) begin
      cyc(1);
      n++;
    end
    chk("done_within_bound", {31'd0, done}, 32'd1);
  endtask

  task automatic run_expect();
    load();
    exp_q.push_back(model());
    pulse_start();
    wait_done();
    cyc(1);
  endtask

  // Monitor: counts busy cycles and checks each completed run against the queued expectation.
  always @(negedge clk) begin
    if (!reset) begin
      busy_cnt  = 0;
      prev_done = 1'b0;
    end else begin
      if (busy) busy_cnt++;
      if (busy && done) chk("busy_and_done", 32'd1, 32'd0);
      if (done && !prev_done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          for (int o = 0; o < NO; o++)
            chk($sformatf("pool[%0d]", o), {16'd0, pool_el(o)}, {16'd0, mon_e[(NO - 1 - o) * DW +: DW]});
          chk("busy_cycles", busy_cnt, NO);
        end
        busy_cnt = 0;
      end
      prev_done = done;
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int n = 0; n < NI; n++) in_mem[n] = '0;
    load();
    #1;
    chk("rst_pool_zero", {31'd0, |outputPool}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    @(posedge clk);
    #2;
    reset = 1'b1;
    cyc(2);

    // Map 0 counts 1..16, map 1 is constant -2.0.
    for (int n = 0; n < 16; n++) begin
      in_mem[n]      = ONE_TO_16[n];
      in_mem[16 + n] = 16'hC000;
    end
    run_expect();
    chk("basic_pool0", {16'd0, pool_el(0)}, 32'h4600);
    chk("basic_pool1", {16'd0, pool_el(1)}, 32'h4800);
    chk("basic_pool2", {16'd0, pool_el(2)}, 32'h4B00);
    chk("basic_pool3", {16'd0, pool_el(3)}, 32'h4C00);
    for (int o = 4; o < 8; o++) chk($sformatf("basic_pool%0d", o), {16'd0, pool_el(o)}, 32'hC000);

    // Negative-only window and signed-zero ties.
    fill_random();
    in_mem[0]  = 16'hBC00; in_mem[1]  = 16'hB800; in_mem[4]  = 16'hC200; in_mem[5]  = 16'hB400;
    in_mem[2]  = 16'h0000; in_mem[3]  = 16'h8000; in_mem[6]  = 16'hBC00; in_mem[7]  = 16'hC000;
    in_mem[8]  = 16'h8000; in_mem[9]  = 16'h0000; in_mem[12] = 16'h8000; in_mem[13] = 16'h0000;
    run_expect();
    chk("neg_window", {16'd0, pool_el(0)}, 32'hB400);
    chk("zero_tie_pos_first", {16'd0, pool_el(1)}, 32'h0000);
    chk("zero_tie_neg_first", {16'd0, pool_el(2)}, 32'h8000);

    for (int r = 0; r < 6; r++) begin
      fill_random();
      run_expect();
    end

    // Held start: one run only, done held until start drops.
    fill_random();
    load();
    exp_q.push_back(model());
    start = 1'b1;
    wait_done();
    cyc(3);
    chk("held_done_stays", {31'd0, done}, 32'd1);
    chk("held_no_rerun", {31'd0, busy}, 32'd0);
    start = 1'b0;
    cyc(1);
    chk("held_back_idle_done", {31'd0, done}, 32'd0);
    chk("held_back_idle_busy", {31'd0, busy}, 32'd0);
    fill_random();
    run_expect();

    // Abort with reset partway through a run.
    fill_random();
    load();
    pulse_start();
    cyc(2);
    reset = 1'b0;
    #1;
    chk("abort_pool_zero", {31'd0, |outputPool}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    cyc(1);
    reset = 1'b1;
    cyc(4);
    chk("abort_idle_busy", {31'd0, busy}, 32'd0);
    chk("abort_idle_done", {31'd0, done}, 32'd0);
    fill_random();
    run_expect();

    // Start pulses during RUN and during DONE must not restart.
    for (int n = 0; n < 16; n++) begin
      in_mem[n]      = ONE_TO_16[n];
      in_mem[16 + n] = 16'hC000;
    end
    load();
    exp_q.push_back(model());
    pulse_start();
    cyc(3);
    pulse_start();
    wait_done();
    start = 1'b1;
    cyc(2);
    start = 1'b0;
    cyc(4);
    chk("no_restart_busy", {31'd0, busy}, 32'd0);
    chk("no_restart_done", {31'd0, done}, 32'd0);
    chk("repeat_pool3", {16'd0, pool_el(3)}, 32'h4C00);

    cyc(3);
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
